// File: rtl/sd_cmd_arbiter.sv
// Round-robin arbiter that shares one SPI command engine between two requesters.
// Each transfer runs LOAD -> START -> WAIT -> RESP. A transfer ends on a done edge or on a timeout.
module sd_cmd_arbiter #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000,
    parameter logic [47:0] IDLE_CMD    = 48'hFFFF_FFFF_FFFF
) (
    input  logic        arb_clk_i,
    input  logic        arb_rst_i,
    input  logic        req0_i,
    input  logic        req1_i,
    input  logic [47:0] cmd0_i,
    input  logic [47:0] cmd1_i,
    output logic        gnt0_o,
    output logic        gnt1_o,
    output logic        done0_o,
    output logic        done1_o,
    output logic [47:0] resp_o,
    output logic        err_o,
    output logic        busy_o,
    output logic [47:0] instruction_sd_o,
    output logic        spi_rst_o,
    output logic        spi_start_o,
    input  logic [47:0] spi_data_i,
    input  logic        spi_done_i
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [47:0] cmd_q, cmd_d;
    logic [47:0] resp_q, resp_d;
    logic [15:0] cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic        err_q, err_d;
    logic [1:0]  done_q, done_d;
    logic        sd_q, sd2_q;
    logic [1:0]  gnt;
    logic        win0, win1, done_edge;

    // last_q = 1 means requester 1 was served last, so requester 0 wins a tie
    assign win0 = req0_i & (~req1_i | last_q);
    assign win1 = req1_i & (~req0_i | ~last_q);

    // An edge seen on the first WAIT cycle reflects a done level that was already high on entry
    assign done_edge = sd_q & ~sd2_q & (cnt_q != 16'd0);

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        resp_d  = resp_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        err_d   = err_q;
        done_d  = 2'b00;
        gnt     = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (win0 | win1) begin
                    gnt     = {win1, win0};
                    owner_d = win1;
                    cmd_d   = win1 ? cmd1_i : cmd0_i;
                    err_d   = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD:  state_d = S_START;
            S_START: begin
                cnt_d   = 16'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                // A timeout wins over a done edge that arrives in the same cycle
                if (cnt_d == TIMEOUT_CYC - 16'd1) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else if (done_edge) begin
                    resp_d  = spi_data_i;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                done_d[owner_q] = 1'b1;
                last_d          = owner_q;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge arb_clk_i or posedge arb_rst_i) begin
        if (arb_rst_i) begin
            state_q <= S_IDLE;
            cmd_q   <= IDLE_CMD;
            resp_q  <= 48'd0;
            cnt_q   <= 16'd0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
            done_q  <= 2'b00;
            sd_q    <= 1'b0;
            sd2_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            resp_q  <= resp_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            err_q   <= err_d;
            done_q  <= done_d;
            sd_q    <= spi_done_i;
            sd2_q   <= sd_q;
        end
    end

    // The IDLE grant is combinational, so it is masked while reset holds the FSM in IDLE
    assign gnt0_o           = gnt[0] & ~arb_rst_i;
    assign gnt1_o           = gnt[1] & ~arb_rst_i;
    assign done0_o          = done_q[0];
    assign done1_o          = done_q[1];
    assign resp_o           = resp_q;
    assign err_o            = err_q;
    assign busy_o           = (state_q != S_IDLE);
    assign instruction_sd_o = (state_q == S_IDLE) ? IDLE_CMD : cmd_q;
    assign spi_rst_o        = (state_q != S_LOAD);
    assign spi_start_o      = (state_q == S_START);

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Bench for sd_cmd_arbiter: a transaction-timeline model is checked every cycle, followed by directed literal checks and a random phase.
module tb_sd_cmd_arbiter;
    localparam logic [15:0] TO   = 16'd16;
    localparam logic [47:0] ICMD = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] DA   = 48'h1234_5678_9ABC;
    localparam logic [47:0] DB   = 48'hABCD_0000_1111;
    localparam logic [47:0] DC   = 48'h0F0F_0F0F_0F0F;

    logic clk = 1'b0, rst = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0;
    logic [47:0] cmd0 = '0, cmd1 = '0;
    logic gnt0, gnt1, done0, done1, err, busy, spi_rst, spi_start;
    logic [47:0] resp, instr;
    logic [47:0] spi_data = '0;
    logic spi_done = 1'b0;

    sd_cmd_arbiter #(.TIMEOUT_CYC(TO), .IDLE_CMD(ICMD)) dut (
        .arb_clk_i(clk), .arb_rst_i(rst), .req0_i(req0), .req1_i(req1),
        .cmd0_i(cmd0), .cmd1_i(cmd1), .gnt0_o(gnt0), .gnt1_o(gnt1),
        .done0_o(done0), .done1_o(done1), .resp_o(resp), .err_o(err),
        .busy_o(busy), .instruction_sd_o(instr), .spi_rst_o(spi_rst),
        .spi_start_o(spi_start), .spi_data_i(spi_data), .spi_done_i(spi_done)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [47:0] rnd48();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[47:0];
    endfunction

    // SPI engine emulation: done drops when a start is seen and rises cd cycles later (cd<0: never)
    bit rand_mode = 0, data_rand = 0, pre_cfg = 0;
    int dly_cfg = -1;
    initial begin
        int cd;
        bit pend_hi, pend_lo;
        cd = -1; pend_hi = 0; pend_lo = 0;
        forever begin
            @(negedge clk);
            if (gnt0 | gnt1) pend_lo = rand_mode ? ($urandom_range(0, 3) == 0) : pre_cfg;
            if (!spi_rst) pend_hi = rand_mode ? ($urandom_range(0, 3) == 0) : pre_cfg;
            if (spi_start) begin
                pend_lo = 1;
                if (rand_mode) begin
                    int r;
                    r  = int'($urandom_range(0, 19));
                    cd = (r < 18) ? r + 1 : -1;
                end else cd = dly_cfg;
            end
            @(posedge clk);
            #1;
            if (pend_hi) spi_done = 1'b1;
            else if (pend_lo) spi_done = 1'b0;
            pend_hi = 0; pend_lo = 0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin spi_done = 1'b1; cd = -1; end
            end
            if (data_rand) spi_data = rnd48();
        end
    end

    // Timeline model: t counts cycles since the grant; WAIT starts at t=3; m_end is the last WAIT cycle
    bit m_active, m_own, m_last, m_err, m_d1, m_d2;
    logic [47:0] m_cmd, m_resp;
    logic [1:0] m_dpend;
    int m_t, m_end, cyc = 0;
    int n_gnt = 0, n_done = 0, g_cyc = 0, d_cyc = 0, r_cyc = 0, s_cyc = 0;
    bit gq[$];

    always @(negedge clk) begin
        bit w0, w1;
        logic [1:0] nd;
        cyc++;
        if (rst) begin
            chk("rst_gnt", {46'd0, gnt1, gnt0}, 48'd0);
            chk("rst_done", {46'd0, done1, done0}, 48'd0);
            chk("rst_err", {47'd0, err}, 48'd0);
            chk("rst_busy", {47'd0, busy}, 48'd0);
            chk("rst_spi", {46'd0, spi_rst, spi_start}, 48'd2);
            chk("rst_instr", instr, ICMD);
            chk("rst_resp", resp, 48'd0);
            m_active = 0; m_last = 1; m_err = 0; m_resp = '0; m_dpend = '0; m_d1 = 0; m_d2 = 0;
        end else begin
            w0 = !m_active && req0 && (!req1 || m_last);
            w1 = !m_active && req1 && (!req0 || !m_last);
            chk("gnt", {46'd0, gnt1, gnt0}, {46'd0, w1, w0});
            chk("done", {46'd0, done1, done0}, {46'd0, m_dpend});
            chk("err", {47'd0, err}, {47'd0, m_err});
            chk("busy", {47'd0, busy}, {47'd0, m_active});
            chk("spi_rst", {47'd0, spi_rst}, {47'd0, !(m_active && m_t == 1)});
            chk("spi_start", {47'd0, spi_start}, {47'd0, m_active && m_t == 2});
            chk("instr", instr, m_active ? m_cmd : ICMD);
            chk("resp", resp, m_resp);
            nd = '0;
            if (m_active) begin
                if (m_end >= 0 && m_t == m_end + 1) begin
                    nd[m_own] = 1'b1; m_last = m_own; m_active = 0;
                end else if (m_t >= 3 && m_end < 0) begin
                    if (m_t - 3 == int'(TO) - 2) begin m_err = 1; m_end = m_t; end
                    else if (m_t - 3 >= 1 && m_d1 && !m_d2) begin m_resp = spi_data; m_end = m_t; end
                end
                m_t++;
            end else if (w0 || w1) begin
                m_active = 1; m_own = w1; m_cmd = w1 ? cmd1 : cmd0;
                m_err = 0; m_t = 1; m_end = -1;
            end
            m_dpend = nd; m_d2 = m_d1; m_d1 = spi_done;
        end
        if (gnt0 | gnt1) begin n_gnt++; gq.push_back(gnt1); g_cyc = cyc; end
        if (done0 | done1) begin n_done++; d_cyc = cyc; end
        if (!spi_rst) r_cyc = cyc;
        if (spi_start) s_cyc = cyc;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
    endtask

    // Issue one request, drop it after the grant, return grant-to-done latency
    task automatic run_one(input bit who, input int dly, input bit pre, output int lat);
        int ng, ndn, b;
        dly_cfg = dly; pre_cfg = pre; ng = n_gnt; ndn = n_done;
        if (who) req1 = 1'b1; else req0 = 1'b1;
        b = 0;
        while (n_gnt == ng && b < 50) begin step(); b++; end
        req0 = 1'b0; req1 = 1'b0;
        if (n_gnt == ng) chk("gnt_wait_expired", 48'd0, 48'd1);
        b = 0;
        while (n_done == ndn && b < 100) begin step(); b++; end
        if (n_done == ndn) chk("done_wait_expired", 48'd0, 48'd1);
        lat = d_cyc - g_cyc;
        step();
    endtask

    initial begin
        int lat, ng, b;
        repeat (3) step();
        chk("lit_reset_busy", {47'd0, busy}, 48'd0);
        chk("lit_reset_instr", instr, 48'hFFFF_FFFF_FFFF);
        rst = 1'b0;
        step();

        spi_data = DA; cmd0 = 48'h400000000095;
        run_one(1'b0, 10, 1'b0, lat);
        chk("single_owner", {47'd0, gq[gq.size()-1]}, 48'd0);
        chk("single_latency", 48'(lat), 48'd15);
        chk("single_rst_low_cycle", 48'(r_cyc - g_cyc), 48'd1);
        chk("single_start_cycle", 48'(s_cyc - g_cyc), 48'd2);
        chk("single_err", {47'd0, err}, 48'd0);
        chk("single_resp", resp, DA);

        spi_data = DC; cmd1 = rnd48();
        run_one(1'b1, -1, 1'b0, lat);
        chk("timeout_latency", 48'(lat), 48'd19);
        chk("timeout_err", {47'd0, err}, 48'd1);
        chk("timeout_resp", resp, DA);

        run_one(1'b0, 14, 1'b0, lat);
        chk("collide_latency", 48'(lat), 48'd19);
        chk("collide_err", {47'd0, err}, 48'd1);
        chk("collide_resp", resp, DA);

        spi_data = DB;
        run_one(1'b1, 6, 1'b1, lat);
        chk("stale_latency", 48'(lat), 48'd11);
        chk("stale_resp", resp, DB);
        chk("stale_err", {47'd0, err}, 48'd0);

        // Reset during WAIT aborts with no done pulse
        dly_cfg = -1; pre_cfg = 0; req0 = 1'b1;
        step(); req0 = 1'b0;
        repeat (6) step();
        ng = n_done;
        rst = 1'b1;
        #2;
        chk("rstwait_busy", {47'd0, busy}, 48'd0);
        chk("rstwait_spi_rst", {47'd0, spi_rst}, 48'd1);
        chk("rstwait_instr", instr, 48'hFFFF_FFFF_FFFF);
        repeat (3) step();
        rst = 1'b0;
        repeat (3) step();
        chk("rstwait_no_done", 48'(n_done - ng), 48'd0);

        // Tie after reset: alternate grants 0,1,0,1
        do_reset();
        dly_cfg = 3; ng = n_gnt;
        req0 = 1'b1; req1 = 1'b1;
        b = 0;
        while (n_gnt < ng + 4 && b < 200) begin step(); b++; end
        req0 = 1'b0; req1 = 1'b0;
        if (n_gnt < ng + 4) chk("tie_wait_expired", 48'd0, 48'd1);
        else for (int i = 0; i < 4; i++) chk("tie_order", {47'd0, gq[ng+i]}, 48'(i % 2));
        repeat (20) step();

        // Random phase
        rand_mode = 1; data_rand = 1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) req0 = ~req0;
            if ($urandom_range(0, 3) == 0) req1 = ~req1;
            cmd0 = rnd48(); cmd1 = rnd48();
            if ($urandom_range(0, 399) == 0) rst = 1'b1;
            else if (rst && $urandom_range(0, 1) == 0) rst = 1'b0;
            step();
        end
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (30) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
